// File: rtl/balun_sweep_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : balun_sweep_ctrl
// Description : Sweep sequencer for the two-port LPF-balun S-parameter
//               measurement. Programs the bias DAC once, then for every
//               frequency point excites port 1 and port 2 in turn, waits a
//               settle time, sums 2^AVG_LOG2 ADC samples and streams the
//               tagged sum out over a valid/ready handshake.
//               Optional macro BALUN_SWEEP_TIMEOUT_EN adds an acquisition
//               watchdog that closes a point with a partial sum.
// Revision    : 1.0 - initial release
// ============================================================================
module balun_sweep_ctrl #(
    parameter int N_FREQ      = 16,
    parameter int FIDX_W      = 4,
    parameter int SETTLE_CYC  = 8,
    parameter int DATA_W      = 12,
    parameter int BIAS_W      = 8,
    parameter int AVG_LOG2    = 2,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic                       abort,
    input  logic [BIAS_W-1:0]          bias_code,
    output logic [BIAS_W-1:0]          dac_bias,
    output logic                       src_en,
    output logic                       port_sel,
    output logic [FIDX_W-1:0]          freq_idx,
    input  logic [DATA_W-1:0]          adc_data,
    input  logic                       adc_valid,
    output logic                       res_valid,
    input  logic                       res_ready,
    output logic [DATA_W+AVG_LOG2-1:0] res_data,
    output logic [FIDX_W-1:0]          res_fidx,
    output logic                       res_port,
    output logic                       acq_timeout,
    output logic                       busy,
    output logic                       done
);

    localparam int c_ACC_W = DATA_W + AVG_LOG2;
    localparam int c_SET_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam int c_SMP_W = AVG_LOG2 + 1;

    localparam logic [c_SET_W-1:0] c_SET_LAST  = c_SET_W'(SETTLE_CYC - 1);
    localparam logic [c_SMP_W-1:0] c_SMP_LAST  = c_SMP_W'((1 << AVG_LOG2) - 1);
    localparam logic [FIDX_W-1:0]  c_FIDX_LAST = FIDX_W'(N_FREQ - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_BIAS   = 3'd1,
        S_SETTLE = 3'd2,
        S_ACQ    = 3'd3,
        S_OUT    = 3'd4,
        S_NEXT   = 3'd5,
        S_DONE   = 3'd6
    } state_t;

    state_t               r_state;
    state_t               w_next_state;
    logic [BIAS_W-1:0]    r_dac_bias;
    logic [FIDX_W-1:0]    r_freq_idx;
    logic                 r_port_sel;
    logic [c_SET_W-1:0]   r_cnt;
    logic [c_SMP_W-1:0]   r_smp;
    logic [c_ACC_W-1:0]   r_acc;
    logic                 w_abort;
    logic                 w_cnt_last;
    logic                 w_wd_fire;

    // Abort only matters once a sweep is running; in IDLE it merely vetoes start.
    assign w_abort    = abort && (r_state != S_IDLE);
    assign w_cnt_last = (r_cnt == c_SET_LAST);

    assign dac_bias = r_dac_bias;
    assign freq_idx = r_freq_idx;
    assign port_sel = r_port_sel;
    // The accumulator doubles as the result register: it only moves in ACQ,
    // so it is stable throughout OUT.
    assign res_data = r_acc;
    assign res_fidx = r_freq_idx;
    assign res_port = r_port_sel;

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode and state-derived outputs; abort overrides everything.
    always_comb begin
        w_next_state = r_state;
        src_en       = 1'b0;
        res_valid    = 1'b0;
        busy         = 1'b1;
        done         = 1'b0;
        case (r_state)
            S_IDLE: begin
                busy = 1'b0;
                if (start && !abort) begin
                    w_next_state = S_BIAS;
                end
            end
            S_BIAS: begin
                if (w_cnt_last) begin
                    w_next_state = S_SETTLE;
                end
            end
            S_SETTLE: begin
                src_en = 1'b1;
                if (w_cnt_last) begin
                    w_next_state = S_ACQ;
                end
            end
            S_ACQ: begin
                src_en = 1'b1;
                if ((adc_valid && (r_smp == c_SMP_LAST)) || w_wd_fire) begin
                    w_next_state = S_OUT;
                end
            end
            S_OUT: begin
                res_valid = 1'b1;
                if (res_ready) begin
                    w_next_state = S_NEXT;
                end
            end
            S_NEXT: begin
                if (!r_port_sel || (r_freq_idx < c_FIDX_LAST)) begin
                    w_next_state = S_SETTLE;
                end else begin
                    w_next_state = S_DONE;
                end
            end
            S_DONE: begin
                busy         = 1'b0;
                done         = 1'b1;
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
        if (w_abort) begin
            w_next_state = S_IDLE;
        end
    end

    // Datapath: bias latch, settle timer, sample counter, accumulator, point index.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_dac_bias <= '0;
            r_freq_idx <= '0;
            r_port_sel <= 1'b0;
            r_cnt      <= '0;
            r_smp      <= '0;
            r_acc      <= '0;
        end else if (w_abort) begin
            r_dac_bias <= '0;
            r_freq_idx <= '0;
            r_port_sel <= 1'b0;
            r_cnt      <= '0;
            r_smp      <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start && !abort) begin
                        r_dac_bias <= bias_code;
                        r_freq_idx <= '0;
                        r_port_sel <= 1'b0;
                        r_cnt      <= '0;
                    end
                end
                S_BIAS: begin
                    r_cnt <= w_cnt_last ? '0 : r_cnt + c_SET_W'(1);
                end
                S_SETTLE: begin
                    r_cnt <= w_cnt_last ? '0 : r_cnt + c_SET_W'(1);
                    r_smp <= '0;
                    r_acc <= '0;
                end
                S_ACQ: begin
                    if (adc_valid) begin
                        r_acc <= r_acc + c_ACC_W'(adc_data);
                        r_smp <= r_smp + c_SMP_W'(1);
                    end
                end
                S_NEXT: begin
                    if (!r_port_sel) begin
                        r_port_sel <= 1'b1;
                    end else if (r_freq_idx < c_FIDX_LAST) begin
                        r_freq_idx <= r_freq_idx + FIDX_W'(1);
                        r_port_sel <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

`ifdef BALUN_SWEEP_TIMEOUT_EN
    localparam int c_WD_W = $clog2(TIMEOUT_CYC + 1);

    logic [c_WD_W-1:0] r_wd;
    logic              r_timeout;

    assign w_wd_fire   = (r_state == S_ACQ) && !adc_valid &&
                         (r_wd == c_WD_W'(TIMEOUT_CYC - 1));
    assign acq_timeout = r_timeout && (r_state == S_OUT);

    // Watchdog: counts consecutive sample-less ACQ cycles and flags a partial result.
    always_ff @(posedge clk) begin
        if (!rst_n || abort) begin
            r_wd      <= '0;
            r_timeout <= 1'b0;
        end else if (r_state == S_SETTLE) begin
            r_wd      <= '0;
            r_timeout <= 1'b0;
        end else if (r_state == S_ACQ) begin
            if (adc_valid) begin
                r_wd <= '0;
            end else if (w_wd_fire) begin
                r_wd      <= '0;
                r_timeout <= 1'b1;
            end else begin
                r_wd <= r_wd + c_WD_W'(1);
            end
        end
    end
`else
    logic w_unused_timeout_cfg;

    assign w_unused_timeout_cfg = (TIMEOUT_CYC != 0);
    assign w_wd_fire            = 1'b0;
    assign acq_timeout          = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_balun_sweep_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_balun_sweep_ctrl
// Description : Self-checking bench for balun_sweep_ctrl. Expected results
//               come from the sweep rules: fixed bias/settle windows, the
//               first 2^AVG_LOG2 valid samples of each point summed, results
//               in (freq, port) order.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_balun_sweep_ctrl;

    localparam int N_FREQ      = 4;
    localparam int FIDX_W      = 2;
    localparam int SETTLE_CYC  = 3;
    localparam int DATA_W      = 12;
    localparam int BIAS_W      = 8;
    localparam int AVG_LOG2    = 2;
    localparam int TIMEOUT_CYC = 20;
    localparam int N_SMP       = 1 << AVG_LOG2;
    localparam int RES_W       = DATA_W + AVG_LOG2;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic              abort = 1'b0;
    logic [BIAS_W-1:0] bias_code = '0;
    logic [DATA_W-1:0] adc_data = '0;
    logic              adc_valid = 1'b0;
    logic              res_ready = 1'b0;
    logic [BIAS_W-1:0] dac_bias;
    logic              src_en;
    logic              port_sel;
    logic [FIDX_W-1:0] freq_idx;
    logic              res_valid;
    logic [RES_W-1:0]  res_data;
    logic [FIDX_W-1:0] res_fidx;
    logic              res_port;
    logic              acq_timeout;
    logic              busy;
    logic              done;

    int                checks = 0;
    int                errors = 0;
    int                done_cnt = 0;
    logic [BIAS_W-1:0] exp_bias = '0;

    always #5 clk = ~clk;

    balun_sweep_ctrl #(
        .N_FREQ     (N_FREQ),
        .FIDX_W     (FIDX_W),
        .SETTLE_CYC (SETTLE_CYC),
        .DATA_W     (DATA_W),
        .BIAS_W     (BIAS_W),
        .AVG_LOG2   (AVG_LOG2),
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .abort      (abort),
        .bias_code  (bias_code),
        .dac_bias   (dac_bias),
        .src_en     (src_en),
        .port_sel   (port_sel),
        .freq_idx   (freq_idx),
        .adc_data   (adc_data),
        .adc_valid  (adc_valid),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_data   (res_data),
        .res_fidx   (res_fidx),
        .res_port   (res_port),
        .acq_timeout(acq_timeout),
        .busy       (busy),
        .done       (done)
    );

    // Count every done pulse seen by the clock.
    always @(posedge clk) begin
        if (done === 1'b1) done_cnt++;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // One sweep. rnd: random data/valid gaps/stalls; hold_first: stall cycles on
    // the first result; kill_pt: point at which to abort (mid-ACQ) or reset (in OUT).
    task automatic run_sweep(input logic [BIAS_W-1:0] bias, input bit rnd,
                             input logic [DATA_W-1:0] fdata, input int hold_first,
                             input int kill_pt, input bit kill_rst);
        logic [RES_W-1:0] exp_sum;
        int nvalid, gap, hold, d0;
        d0 = done_cnt;
        start = 1'b1; abort = 1'b0; bias_code = bias;
        tick();
        start = 1'b0; bias_code = BIAS_W'($urandom);
        checks++;
        if ({busy, src_en, dac_bias, freq_idx, port_sel} !== {1'b1, 1'b0, bias, 2'd0, 1'b0}) begin
            errors++;
            $display("FAIL sweep_start: got %h expected %h",
                     {busy, src_en, dac_bias, freq_idx, port_sel}, {1'b1, 1'b0, bias, 2'd0, 1'b0});
        end
        for (int i = 0; i < 2 * SETTLE_CYC; i++) begin
            adc_valid = 1'($urandom); adc_data = DATA_W'($urandom);
            start = 1'($urandom); res_ready = 1'($urandom);
            tick();
            checks++;
            if (src_en !== (i >= SETTLE_CYC - 1)) begin
                errors++;
                $display("FAIL bias_settle_src_en: cycle %0d got %b expected %b", i, src_en, (i >= SETTLE_CYC - 1));
            end
        end
        for (int pt = 0; pt < 2 * N_FREQ; pt++) begin
            exp_sum = '0; nvalid = 0; gap = 0;
            while (nvalid < N_SMP) begin
                if (rnd) begin
                    adc_valid = (($urandom % 3) != 0) || (gap >= 3);
                    adc_data  = DATA_W'($urandom);
                end else begin
                    adc_valid = 1'b1;
                    adc_data  = fdata;
                end
                gap = adc_valid ? 0 : gap + 1;
                start = 1'($urandom); res_ready = 1'($urandom);
                if (pt == kill_pt && !kill_rst && nvalid == N_SMP / 2) begin
                    abort = 1'b1;
                    tick();
                    abort = 1'b0; start = 1'b0;
                    checks++;
                    if ({src_en, res_valid, busy, dac_bias, done} !== '0) begin
                        errors++;
                        $display("FAIL abort_outputs: got %h expected 0", {src_en, res_valid, busy, dac_bias, done});
                    end
                    tick();
                    checks++;
                    if (done_cnt !== d0) begin
                        errors++;
                        $display("FAIL abort_no_done: got %0d done pulses expected 0", done_cnt - d0);
                    end
                    exp_bias = '0;
                    return;
                end
                if (adc_valid) begin
                    exp_sum = exp_sum + RES_W'(adc_data);
                    nvalid++;
                end
                tick();
                if (nvalid < N_SMP) begin
                    checks++;
                    if ({src_en, res_valid} !== 2'b10) begin
                        errors++;
                        $display("FAIL acq_state: point %0d got %b expected 10", pt, {src_en, res_valid});
                    end
                end
            end
            start = 1'b0;
            checks++;
            if ({res_valid, src_en, res_fidx, res_port, acq_timeout} !==
                {1'b1, 1'b0, FIDX_W'(pt / 2), 1'(pt % 2), 1'b0}) begin
                errors++;
                $display("FAIL result_tag: point %0d got %b expected %b", pt,
                         {res_valid, src_en, res_fidx, res_port, acq_timeout},
                         {1'b1, 1'b0, FIDX_W'(pt / 2), 1'(pt % 2), 1'b0});
            end
            checks++;
            if (res_data !== exp_sum) begin
                errors++;
                $display("FAIL result_data: point %0d got %h expected %h", pt, res_data, exp_sum);
            end
            if (pt == kill_pt && kill_rst) begin
                rst_n = 1'b0; res_ready = 1'b1;
                tick();
                checks++;
                if ({dac_bias, src_en, port_sel, freq_idx, res_valid, res_data, res_fidx,
                     res_port, acq_timeout, busy, done} !== '0) begin
                    errors++;
                    $display("FAIL reset_in_out: got %h expected 0",
                             {dac_bias, src_en, port_sel, freq_idx, res_valid, res_data,
                              res_fidx, res_port, acq_timeout, busy, done});
                end
                rst_n = 1'b1; res_ready = 1'b0;
                tick();
                checks++;
                if (done_cnt !== d0) begin
                    errors++;
                    $display("FAIL reset_no_done: got %0d done pulses expected 0", done_cnt - d0);
                end
                exp_bias = '0;
                return;
            end
            hold = (pt == 0) ? hold_first : (rnd ? int'($urandom_range(0, 3)) : 0);
            for (int h = 0; h < hold; h++) begin
                res_ready = 1'b0; adc_valid = 1'b1; adc_data = 12'hFFF; start = 1'($urandom);
                tick();
                checks++;
                if ({res_valid, res_data} !== {1'b1, exp_sum}) begin
                    errors++;
                    $display("FAIL result_hold: point %0d got %h expected %h", pt,
                             {res_valid, res_data}, {1'b1, exp_sum});
                end
            end
            res_ready = 1'b1; adc_valid = 1'($urandom); adc_data = DATA_W'($urandom); start = 1'b0;
            tick();
            checks++;
            if (res_valid !== 1'b0) begin
                errors++;
                $display("FAIL handshake_drop: point %0d got %b expected 0", pt, res_valid);
            end
            if (pt < 2 * N_FREQ - 1) begin
                for (int i = 0; i <= SETTLE_CYC; i++) begin
                    adc_valid = 1'($urandom); adc_data = DATA_W'($urandom);
                    start = 1'($urandom); res_ready = 1'($urandom);
                    tick();
                    checks++;
                    if ({src_en, res_valid, freq_idx, port_sel} !==
                        {1'b1, 1'b0, FIDX_W'((pt + 1) / 2), 1'((pt + 1) % 2)}) begin
                        errors++;
                        $display("FAIL next_point: point %0d got %b expected %b", pt + 1,
                                 {src_en, res_valid, freq_idx, port_sel},
                                 {1'b1, 1'b0, FIDX_W'((pt + 1) / 2), 1'((pt + 1) % 2)});
                    end
                end
            end
        end
        start = 1'b0; res_ready = 1'b0; adc_valid = 1'b0;
        tick();
        checks++;
        if ({done, busy, res_valid} !== 3'b100) begin
            errors++;
            $display("FAIL done_pulse: got %b expected 100", {done, busy, res_valid});
        end
        tick();
        checks++;
        if ({done, busy, dac_bias} !== {2'b00, bias}) begin
            errors++;
            $display("FAIL sweep_idle: got %h expected %h", {done, busy, dac_bias}, {2'b00, bias});
        end
        checks++;
        if (done_cnt - d0 !== 1) begin
            errors++;
            $display("FAIL done_count: got %0d expected 1", done_cnt - d0);
        end
        exp_bias = bias;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        tick(); tick();
        checks++;
        if ({dac_bias, src_en, port_sel, freq_idx, res_valid, res_data, res_fidx,
             res_port, acq_timeout, busy, done} !== '0) begin
            errors++;
            $display("FAIL reset_state: got %h expected 0",
                     {dac_bias, src_en, port_sel, freq_idx, res_valid, res_data,
                      res_fidx, res_port, acq_timeout, busy, done});
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic_sweep;
        run_sweep(8'h5A, 1'b0, 12'h100, 0, -1, 1'b0);
    endtask

    task automatic test_backpressure;
        run_sweep(8'h33, 1'b0, 12'h100, 10, -1, 1'b0);
    endtask

    task automatic test_full_scale;
        run_sweep(8'hC3, 1'b0, 12'hFFF, 0, -1, 1'b0);
    endtask

    task automatic test_abort;
        run_sweep(8'h77, 1'b1, 12'h000, 0, 2, 1'b0);
        run_sweep(8'h19, 1'b1, 12'h000, 0, -1, 1'b0);
    endtask

    task automatic test_start_abort_idle;
        start = 1'b1; abort = 1'b1; bias_code = 8'hEE;
        tick();
        start = 1'b0; abort = 1'b0;
        checks++;
        if ({busy, src_en, dac_bias} !== {1'b0, 1'b0, exp_bias}) begin
            errors++;
            $display("FAIL start_abort_idle: got %h expected %h", {busy, src_en, dac_bias}, {1'b0, 1'b0, exp_bias});
        end
        tick();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL start_abort_idle_hold: got %b expected 0", busy);
        end
    endtask

    task automatic test_reset_in_out;
        run_sweep(8'hA5, 1'b1, 12'h000, 0, 3, 1'b1);
        run_sweep(8'h42, 1'b0, 12'h2AB, 0, -1, 1'b0);
    endtask

    task automatic test_random;
        for (int s = 0; s < 3; s++) begin
            run_sweep(BIAS_W'($urandom), 1'b1, 12'h000, int'($urandom_range(0, 5)), -1, 1'b0);
        end
    endtask

    task automatic test_timeout;
        start = 1'b1; abort = 1'b0; bias_code = 8'h21; res_ready = 1'b0;
        tick();
        start = 1'b0;
        for (int i = 0; i < 2 * SETTLE_CYC; i++) begin
            adc_valid = 1'b0;
            tick();
        end
        adc_valid = 1'b1; adc_data = 12'h010;
        tick();
        adc_valid = 1'b0;
`ifdef BALUN_SWEEP_TIMEOUT_EN
        begin
            int k;
            k = 0;
            while (res_valid !== 1'b1 && k < 40) begin
                tick();
                k++;
            end
            checks++;
            if (k !== TIMEOUT_CYC) begin
                errors++;
                $display("FAIL timeout_latency: got %0d cycles expected %0d", k, TIMEOUT_CYC);
            end
            checks++;
            if ({res_valid, res_data, acq_timeout, res_fidx, res_port} !==
                {1'b1, RES_W'(16), 1'b1, 2'd0, 1'b0}) begin
                errors++;
                $display("FAIL timeout_result: got %h expected %h",
                         {res_valid, res_data, acq_timeout, res_fidx, res_port},
                         {1'b1, RES_W'(16), 1'b1, 2'd0, 1'b0});
            end
            res_ready = 1'b1;
            tick();
            res_ready = 1'b0;
            tick();
            checks++;
            if ({src_en, port_sel, acq_timeout} !== 3'b110) begin
                errors++;
                $display("FAIL timeout_continue: got %b expected 110", {src_en, port_sel, acq_timeout});
            end
        end
`else
        for (int i = 0; i < 40; i++) begin
            tick();
            checks++;
            if ({res_valid, acq_timeout, src_en} !== 3'b001) begin
                errors++;
                $display("FAIL no_timeout: cycle %0d got %b expected 001", i, {res_valid, acq_timeout, src_en});
            end
        end
`endif
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checks++;
        if ({busy, src_en, dac_bias} !== '0) begin
            errors++;
            $display("FAIL timeout_abort: got %h expected 0", {busy, src_en, dac_bias});
        end
    endtask

    initial begin
        test_reset();
        test_basic_sweep();
        test_backpressure();
        test_full_scale();
        test_abort();
        test_start_abort_idle();
        test_reset_in_out();
        test_random();
        test_timeout();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish, limit 2000000 expected earlier end");
        $fatal(1, "simulation time limit reached");
    end

endmodule
`default_nettype wire

// File: doc/balun_sweep_ctrl.md
Name: balun_sweep_ctrl

Overview:
- Sequencer for the two-port LPF-balun S-parameter measurement datapath.
- Programs the DC bias source once per sweep, then steps the frequency index and excites port 1 and port 2 in turn.
- Waits a settle time at each point, averages the probe ADC samples, and streams each result out over a valid/ready handshake.

Parameters:
- N_FREQ, 16: frequency points per sweep (>=1).
- FIDX_W, 4: freq_idx width; must satisfy 2^FIDX_W >= N_FREQ.
- SETTLE_CYC, 8: settle cycles, applied after bias and before every point (>=1).
- DATA_W, 12: ADC sample width, unsigned.
- BIAS_W, 8: bias DAC code width.
- AVG_LOG2, 2: 2^AVG_LOG2 samples are summed per point.
- TIMEOUT_CYC, 64: acquisition watchdog limit; used only with the optional feature.

Ports:
- clk, in, 1: clock; all logic on the rising edge.
- rst_n, in, 1: synchronous active-low reset.
- start, in, 1: sweep request, sampled in IDLE only.
- abort, in, 1: cancel the sweep; valid in any state.
- bias_code, in, BIAS_W: bias value, latched when start is accepted.
- dac_bias, out, BIAS_W: bias DAC drive.
- src_en, out, 1: RF source enable.
- port_sel, out, 1: excited port; 0 = P1, 1 = P2.
- freq_idx, out, FIDX_W: current frequency point.
- adc_data, in, DATA_W: probe sample.
- adc_valid, in, 1: adc_data qualifier.
- res_valid, out, 1: result valid.
- res_ready, in, 1: result accepted.
- res_data, out, DATA_W+AVG_LOG2: unsigned sample sum.
- res_fidx, out, FIDX_W: freq_idx tag for the result.
- res_port, out, 1: port_sel tag for the result.
- acq_timeout, out, 1: result carries a partial sum because of a timeout.
- busy, out, 1: high in every state except IDLE.
- done, out, 1: one-cycle pulse when a sweep completes.

Behaviour:
- Reset (rst_n=0 at an edge, any state): FSM=IDLE; every output is 0 on the next edge. Counters and accumulator clear. Mid-sweep reset discards the sweep and emits no done.
- FSM states: IDLE, BIAS, SETTLE, ACQ, OUT, NEXT, DONE.
- IDLE
  - start=1 and abort=0 -> BIAS; dac_bias<=bias_code; freq_idx=0; port_sel=0; busy=1 from the next cycle.
  - start=1 and abort=1 -> stay in IDLE.
- BIAS: wait SETTLE_CYC cycles with src_en=0 -> SETTLE.
- SETTLE
  - src_en=1; wait SETTLE_CYC cycles; accumulator cleared.
  - adc_valid in this state is ignored.
  - -> ACQ.
- ACQ
  - src_en=1; each adc_valid adds adc_data to the accumulator (zero-extended) and increments the sample count.
  - On the 2^AVG_LOG2-th sample -> OUT.
  - Each sum is registered into res_data on the same edge it is accumulated.
- OUT
  - src_en=0; res_valid=1; res_data, res_fidx and res_port stay stable until res_valid && res_ready.
  - adc_valid is ignored.
  - The handshake completes at the edge -> NEXT; res_valid=0 on the following cycle.
- NEXT (single cycle)
  - port_sel=0 -> port_sel=1, go to SETTLE.
  - Otherwise, freq_idx<N_FREQ-1 -> freq_idx+1, port_sel=0, go to SETTLE.
  - Otherwise -> DONE.
- DONE: done=1 for one cycle, busy=0, dac_bias held -> IDLE.
- Result order: (0,P1), (0,P2), (1,P1) … (N_FREQ-1,P2); 2*N_FREQ results in total.
- No overflow: the maximum sum is (2^DATA_W-1)*2^AVG_LOG2, which fits in DATA_W+AVG_LOG2 bits.
- abort=1 in a non-IDLE state
  - Next edge: IDLE; src_en=0, res_valid=0, busy=0, no done pulse.
  - abort overrides a same-cycle handshake; that result is dropped.
  - dac_bias resets to 0.
- start while busy: ignored.
- A latency of one cycle from an ADC sample to res_valid is permitted only for the final sample of a point.

Optional Feature:
- Macro: BALUN_SWEEP_TIMEOUT_EN.
- Defined
  - A watchdog counts consecutive ACQ cycles without adc_valid.
  - When the count reaches TIMEOUT_CYC, the FSM goes to OUT with the partial sum and acq_timeout=1, qualified by res_valid.
  - The sweep then continues normally.
  - The watchdog clears on every adc_valid and on entry to SETTLE.
- Undefined: no watchdog logic; acq_timeout tied to 0; ACQ waits indefinitely.

Test Plan:
Bench parameters: N_FREQ=4, SETTLE_CYC=3, AVG_LOG2=2, DATA_W=12.
1. start with bias_code=0x5A, res_ready=1, adc_valid=1, adc_data=0x100 -> dac_bias=0x5A; 8 results, each res_data=0x400, in order (0,0),(0,1),(1,0)…(3,1); exactly one done pulse; busy=0 afterwards.
2. Hold res_ready=0 for 10 cycles at the first result while driving adc_valid with data 0xFFF -> res_valid stays 1; res_data stays 0x400 and stable; nothing is accumulated.
3. adc_data=0xFFF for all four samples -> res_data=0x3FFC.
4. abort during ACQ of the third point -> next cycle src_en=0, res_valid=0, busy=0, dac_bias=0; no done; a later start runs a full 8-result sweep.
5. start and abort asserted together in IDLE -> remains IDLE. start asserted mid-sweep -> no effect on the sequence. rst_n=0 during OUT -> all outputs 0 on the next edge.
6. With BALUN_SWEEP_TIMEOUT_EN and TIMEOUT_CYC=20: one sample of 0x010, then adc_valid=0 -> 20 cycles later res_valid=1, res_data=0x010, acq_timeout=1; the sweep continues. Without the macro -> acq_timeout is always 0 and the FSM stays in ACQ.
